// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, fetches one instruction at a time from imem over a
// req/rvalid handshake, and presents pc/inst to the IF/ID register.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8020_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [63:0] o_pc_if,
    output logic [31:0] o_inst_if,
    output logic        o_inst_valid,
    output logic        o_fetch_busy,
    output logic        o_misalign
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc_q;
    logic [XLEN-1:0]   r_req_addr;
    logic [ILEN-1:0]   r_inst_buf;
    logic              r_misalign;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_req_addr_nxt;
    logic [ILEN-1:0]   w_inst_buf_nxt;
    logic              w_misalign_nxt;
    logic [XLEN-1:0]   w_tgt;
    logic [XLEN-1:0]   w_pc_seq;

    // Word-aligned redirect target and sequential successor (wraps mod 2^64)
    assign w_tgt    = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_pc_seq = r_pc_q + XLEN'(PC_STEP);

    // State register: async reset, all state frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc_q     <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_inst_buf <= NOP_INST;
            r_misalign <= 1'b0;
        end else if (i_en) begin
            r_state    <= w_state_nxt;
            r_pc_q     <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_inst_buf <= w_inst_buf_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // Next-state and next-register values
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc_q;
        w_req_addr_nxt = r_req_addr;
        w_inst_buf_nxt = r_inst_buf;
        w_misalign_nxt = i_redirect & (i_redirect_pc[1:0] != 2'b00);

        unique case (r_state)
            IDLE: begin
                w_req_addr_nxt = r_pc_q;
                w_state_nxt    = FETCH;
            end
            FETCH: begin
                if (i_redirect && i_imem_rvalid) begin
                    // Response belongs to the old path; reissue at the target
                    w_pc_nxt       = w_tgt;
                    w_req_addr_nxt = w_tgt;
                end else if (i_redirect) begin
                    // Request in flight: keep its address until the stale data returns
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = DRAIN;
                end else if (i_imem_rvalid) begin
                    w_inst_buf_nxt = i_imem_rdata;
                    w_state_nxt    = READY;
                end
            end
            DRAIN: begin
                if (i_redirect) begin
                    w_pc_nxt = w_tgt;
                end
                if (i_imem_rvalid) begin
                    w_req_addr_nxt = i_redirect ? w_tgt : r_pc_q;
                    w_state_nxt    = FETCH;
                end
            end
            READY: begin
                if (i_redirect) begin
                    w_pc_nxt       = w_tgt;
                    w_req_addr_nxt = w_tgt;
                    w_inst_buf_nxt = NOP_INST;
                    w_state_nxt    = FETCH;
                end else if (!i_stall) begin
                    w_pc_nxt       = w_pc_seq;
                    w_req_addr_nxt = w_pc_seq;
                    w_state_nxt    = FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded directly from registered state
    assign o_pc_if      = r_pc_q;
    assign o_inst_valid = (r_state == READY);
    assign o_inst_if    = (r_state == READY) ? r_inst_buf : NOP_INST;
    assign o_imem_req   = (r_state == FETCH) || (r_state == DRAIN);
    assign o_fetch_busy = o_imem_req;
    assign o_imem_addr  = r_req_addr;
    assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a scoreboard of expected (pc, inst) pairs.
module tb_if_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8020_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        en;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [63:0] pc_if;
    logic [31:0] inst_if;
    logic        inst_valid;
    logic        fetch_busy;
    logic        misalign;

    int total;
    int bad;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (en),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_pc_if       (pc_if),
        .o_inst_if     (inst_if),
        .o_inst_valid  (inst_valid),
        .o_fetch_busy  (fetch_busy),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a response for the current request and record what must appear
    task automatic respond(input logic [31:0] data);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb_q.push_back('{pc: imem_addr, inst: data});
    endtask

    // Compare the presented instruction against the oldest expectation
    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(inst_valid), 64'd1);
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_pc"},   pc_if,          e.pc);
            chk({tag, "_inst"}, 64'(inst_if),   64'(e.inst));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset values
        #12;
        chk("rst_req",   64'(imem_req),   64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst",  64'(inst_if),    64'(NOP));
        chk("rst_pc",    pc_if,           RST_PC);
        chk("rst_busy",  64'(fetch_busy), 64'd0);
        chk("rst_mis",   64'(misalign),   64'd0);
        rst = 1'b0;

        // 1: first fetch, zero-wait response
        step();
        chk("t1_req",  64'(imem_req), 64'd1);
        chk("t1_addr", imem_addr,     RST_PC);
        respond(32'h0050_0093);
        stall = 1'b1;
        step();
        imem_rvalid = 1'b0;
        pop_check("t1");
        chk("t1_busy", 64'(fetch_busy), 64'd0);

        // 2: stall holds READY for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_inst", 64'(inst_if),  64'h0050_0093);
            chk("t2_hold_pc",   pc_if,         RST_PC);
            chk("t2_hold_req",  64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        step();
        chk("t2_addr",  imem_addr,        RST_PC + 64'd4);
        chk("t2_req",   64'(imem_req),    64'd1);
        chk("t2_valid", 64'(inst_valid),  64'd0);
        respond(32'h00a0_0113);
        step();
        imem_rvalid = 1'b0;
        pop_check("t2");

        // 3: redirect beats stall in READY
        redirect = 1'b1; redirect_pc = 64'h8020_0100; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("t3_addr",  imem_addr,       64'h8020_0100);
        chk("t3_valid", 64'(inst_valid), 64'd0);
        chk("t3_inst",  64'(inst_if),    64'(NOP));

        // Redirect coinciding with rvalid: data dropped, refetch at target
        redirect = 1'b1; redirect_pc = 64'h8020_0008;
        imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
        step();
        redirect = 1'b0; imem_rvalid = 1'b0;
        chk("t3b_addr",  imem_addr,       64'h8020_0008);
        chk("t3b_valid", 64'(inst_valid), 64'd0);
        chk("t3b_busy",  64'(fetch_busy), 64'd1);

        // 4: redirect without rvalid drains the outstanding request
        redirect = 1'b1; redirect_pc = 64'h8020_0040;
        step();
        redirect = 1'b0;
        chk("t4_drain_addr", imem_addr,       64'h8020_0008);
        chk("t4_drain_req",  64'(imem_req),   64'd1);
        chk("t4_drain_pc",   pc_if,           64'h8020_0040);
        step();
        chk("t4_drain_addr2", imem_addr,      64'h8020_0008);
        imem_rvalid = 1'b1; imem_rdata = 32'hbadb_ad00;
        step();
        imem_rvalid = 1'b0;
        chk("t4_new_addr", imem_addr,       64'h8020_0040);
        chk("t4_valid",    64'(inst_valid), 64'd0);
        respond(32'h0010_0193);
        step();
        imem_rvalid = 1'b0;
        pop_check("t4");

        // 5: misaligned redirect target
        redirect = 1'b1; redirect_pc = 64'h8020_0042;
        step();
        redirect = 1'b0;
        chk("t5_mis1", 64'(misalign), 64'd1);
        chk("t5_addr", imem_addr,     64'h8020_0040);
        step();
        chk("t5_mis0", 64'(misalign), 64'd0);

        // 6: reset mid-fetch drops the request asynchronously
        redirect = 1'b1; redirect_pc = 64'h8020_0010;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        redirect = 1'b0; imem_rvalid = 1'b0;
        chk("t6_addr", imem_addr,     64'h8020_0010);
        chk("t6_req",  64'(imem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 64'(imem_req), 64'd0);
        chk("t6_rst_pc",  pc_if,         RST_PC);
        #3;
        rst = 1'b0;
        step();
        chk("t6_addr_after", imem_addr, RST_PC);

        // en=0 freezes state even with rvalid presented
        en = 1'b0;
        respond(32'h0020_0213);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6_en_valid", 64'(inst_valid), 64'd0);
            chk("t6_en_req",   64'(imem_req),   64'd1);
            chk("t6_en_addr",  imem_addr,       RST_PC);
        end
        en = 1'b1;
        step();
        imem_rvalid = 1'b0;
        pop_check("t6_en");

        // PC wraps modulo 2^64 on sequential advance
        redirect = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
        step();
        redirect = 1'b0;
        respond(32'h0000_0033);
        step();
        imem_rvalid = 1'b0;
        pop_check("wrap");
        step();
        chk("wrap_addr", imem_addr, 64'd0);
        chk("wrap_pc",   pc_if,     64'd0);

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
